// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: pipeline stage register/enable info in, stall and forwarding controls out.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             EX_Load_Instr;
    logic             EX_RF_Enable;
    logic [4:0]       EX_RD;
    logic             MEM_RF_Enable;
    logic [4:0]       MEM_RD;
    logic             WB_RF_Enable;
    logic [4:0]       WB_RD;
    logic [4:0]       ID_RS1;
    logic [4:0]       ID_RS2;
    logic [4:0]       ID_RD;
    logic             ID_Use_RS1;
    logic             ID_Use_RS2;
    logic             ID_Use_RD;
    logic             CU_Mux_Sel;
    logic             PC_LE;
    logic             nPC_LE;
    logic             IF_ID_LE;
    logic [1:0]       FW_PA_Sel;
    logic [1:0]       FW_PB_Sel;
    logic [1:0]       FW_PC_Sel;
    logic [CNT_W-1:0] Stall_Count;

    // Pipeline side: presents stage contents, consumes stall/forward controls.
    modport master (
        output EX_Load_Instr, EX_RF_Enable, EX_RD,
        output MEM_RF_Enable, MEM_RD, WB_RF_Enable, WB_RD,
        output ID_RS1, ID_RS2, ID_RD, ID_Use_RS1, ID_Use_RS2, ID_Use_RD,
        input  CU_Mux_Sel, PC_LE, nPC_LE, IF_ID_LE,
        input  FW_PA_Sel, FW_PB_Sel, FW_PC_Sel, Stall_Count
    );

    // Controller side.
    modport slave (
        input  EX_Load_Instr, EX_RF_Enable, EX_RD,
        input  MEM_RF_Enable, MEM_RD, WB_RF_Enable, WB_RD,
        input  ID_RS1, ID_RS2, ID_RD, ID_Use_RS1, ID_Use_RS2, ID_Use_RD,
        output CU_Mux_Sel, PC_LE, nPC_LE, IF_ID_LE,
        output FW_PA_Sel, FW_PB_Sel, FW_PC_Sel, Stall_Count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall sequencing, operand forwarding
// selects and a saturating stalled-cycle counter for performance debug.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] LSTALL = 1'b1;

    localparam logic [2:0] EXTRA_STALLS = 3'(LOAD_STALL_CYCLES - 1);

    logic [0:0]       state;
    logic [2:0]       cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             hz;
    logic             stall;
    logic [1:0]       fw_a;
    logic [1:0]       fw_b;
    logic [1:0]       fw_c;

    // Source field depends on a stage's result; r0 never matches.
    function automatic logic src_match(input logic use_f, input logic en,
                                       input logic [4:0] rd, input logic [4:0] f);
        return use_f && en && (rd == f) && (f != 5'd0);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else register file.
    function automatic logic [1:0] fw_sel(
        input logic use_f, input logic [4:0] f,
        input logic ex_en, input logic [4:0] ex_rd,
        input logic mem_en, input logic [4:0] mem_rd,
        input logic wb_en, input logic [4:0] wb_rd);
        if (src_match(use_f, ex_en, ex_rd, f))
            return 2'b01;
        else if (src_match(use_f, mem_en, mem_rd, f))
            return 2'b10;
        else if (src_match(use_f, wb_en, wb_rd, f))
            return 2'b11;
        else
            return 2'b00;
    endfunction

    // Load-use hazard detection, stall decision and forwarding selects.
    always_comb begin
        hz = bus.EX_Load_Instr &&
             (src_match(bus.ID_Use_RS1, bus.EX_RF_Enable, bus.EX_RD, bus.ID_RS1) ||
              src_match(bus.ID_Use_RS2, bus.EX_RF_Enable, bus.EX_RD, bus.ID_RS2) ||
              src_match(bus.ID_Use_RD,  bus.EX_RF_Enable, bus.EX_RD, bus.ID_RD));
        stall = (state == LSTALL) || hz;
        fw_a = fw_sel(bus.ID_Use_RS1, bus.ID_RS1, bus.EX_RF_Enable, bus.EX_RD,
                      bus.MEM_RF_Enable, bus.MEM_RD, bus.WB_RF_Enable, bus.WB_RD);
        fw_b = fw_sel(bus.ID_Use_RS2, bus.ID_RS2, bus.EX_RF_Enable, bus.EX_RD,
                      bus.MEM_RF_Enable, bus.MEM_RD, bus.WB_RF_Enable, bus.WB_RD);
        fw_c = fw_sel(bus.ID_Use_RD, bus.ID_RD, bus.EX_RF_Enable, bus.EX_RD,
                      bus.MEM_RF_Enable, bus.MEM_RD, bus.WB_RF_Enable, bus.WB_RD);
    end

    // Stall sequencer: the first bubble comes from hz in RUN, the remaining
    // LOAD_STALL_CYCLES-1 bubbles are counted out in LSTALL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz && (LOAD_STALL_CYCLES > 1)) begin
                        state <= LSTALL;
                        cnt   <= EXTRA_STALLS;
                    end
                end
                LSTALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= RUN;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // Reset forces bubble, frozen front end and register-file operands.
    always_comb begin
        bus.CU_Mux_Sel  = !reset && !stall;
        bus.PC_LE       = !reset && !stall;
        bus.nPC_LE      = !reset && !stall;
        bus.IF_ID_LE    = !reset && !stall;
        bus.FW_PA_Sel   = reset ? 2'b00 : fw_a;
        bus.FW_PB_Sel   = reset ? 2'b00 : fw_b;
        bus.FW_PC_Sel   = reset ? 2'b00 : fw_c;
        bus.Stall_Count = stall_cnt;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage SPARC8 core.
- Detects load-use and RAW hazards between ID and the EX/MEM/WB stages.
- Drives the bubble-select of the control-unit mux, plus PC, nPC and IF/ID load enables.
- Generates operand-forwarding selects for the ID-stage operand muxes.
- Sequences multi-cycle load stalls and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- EX_Load_Instr  in  1  instruction in EX is a load
- EX_RF_Enable  in  1  EX instruction writes the register file
- EX_RD  in  5  EX destination register
- MEM_RF_Enable  in  1  MEM instruction writes the register file
- MEM_RD  in  5  MEM destination register
- WB_RF_Enable  in  1  WB instruction writes the register file
- WB_RD  in  5  WB destination register
- ID_RS1  in  5  ID source register 1
- ID_RS2  in  5  ID source register 2
- ID_RD  in  5  ID rd, read as a source by stores
- ID_Use_RS1, ID_Use_RS2, ID_Use_RD  in  1 each  ID instruction reads that field
- CU_Mux_Sel  out  1  1 = pass control signals, 0 = bubble (all zero)
- PC_LE, nPC_LE, IF_ID_LE  out  1 each  load enables
- FW_PA_Sel, FW_PB_Sel, FW_PC_Sel  out  2 each  operand source for RS1, RS2 and RD: 00 RF, 01 EX, 10 MEM, 11 WB
- Stall_Count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Match rule: a source field matches a stage when all of these hold:
  - its Use bit is 1;
  - the stage RF_Enable is 1;
  - the stage RD equals the field;
  - the field is not 0 (r0 is never matched or forwarded).
- Forwarding (combinational, every cycle, any state):
  - priority EX > MEM > WB, else 00;
  - a load in EX still selects 01, but the stall logic guarantees the value is never consumed.
- Hazard (combinational): hz = EX_Load_Instr and a match on EX for any of RS1, RS2 or RD.
- Stall outputs: when stall is active, CU_Mux_Sel = 0 and PC_LE = nPC_LE = IF_ID_LE = 0. Otherwise all four are 1.
- FSM states: RUN, LSTALL. Counter cnt is 3 bits.
  - RUN: stall = hz.
    - If hz and LOAD_STALL_CYCLES > 1: go to LSTALL, cnt <= LOAD_STALL_CYCLES - 1.
    - Otherwise stay in RUN.
  - LSTALL: stall = 1 unconditionally (the load has moved to MEM and the EX inputs are a bubble).
    - cnt decrements each cycle.
    - When cnt == 1: return to RUN on the next edge.
  - Total stalled cycles per hazard = LOAD_STALL_CYCLES exactly.
- Back-to-back hazards: on returning to RUN, hz is re-evaluated the same cycle. A new hazard restarts the sequence with no gap cycle.
- Stall_Count: increments by 1 on each rising edge where stall = 1. It saturates at all-ones and does not wrap.
- Reset (asynchronous, mid-stall included):
  - state = RUN, cnt = 0, Stall_Count = 0;
  - while reset is high: CU_Mux_Sel = 0, all LEs = 0, all FW selects = 00.
- First edge after reset release: normal evaluation; there is no extra startup cycle.
- Simultaneous: a hazard during saturation leaves Stall_Count unchanged and still stalls. Forwarding selects stay valid during a stall, since they follow the current stage contents.

Test Plan:
1. LOAD_STALL_CYCLES = 1, EX load to r5, ID_RS1 = 5, Use_RS1 = 1 → one cycle with CU_Mux_Sel = 0 and LEs = 0. Next cycle (load in MEM) all 1 and FW_PA_Sel = 10; Stall_Count = 1.
2. Non-load ALU in EX writes r5, MEM also writes r5, ID_RS2 = 5 → no stall, FW_PB_Sel = 01. With EX_RF_Enable = 0 → FW_PB_Sel = 10. With EX and MEM disabled, WB rd = 5 → FW_PB_Sel = 11.
3. EX load to r0 with ID_RS1 = 0 → no stall, FW_PA_Sel = 00. Store with ID_RD = 7 matching an EX load to r7 (Use_RD = 1) → stall.
4. LOAD_STALL_CYCLES = 3, hazard → exactly 3 stalled cycles, back to RUN, Stall_Count = 3. A second hazard immediately after → 3 more cycles, Stall_Count = 6.
5. LOAD_STALL_CYCLES = 3, assert reset in the 2nd stall cycle → outputs go to reset values immediately. After release: RUN, CU_Mux_Sel = 1, Stall_Count = 0.
6. CNT_W = 4, force 20 stall cycles → Stall_Count holds at 15.
